// File: rtl/axi_llc_way_port_arbiter.sv
// Round-robin arbiter sharing one LLC data-way port between several requesters.
// Winner indices are queued in order so way responses are routed back to their issuer.
module axi_llc_way_port_arbiter #(
   parameter int unsigned NumReq         = 2,
   parameter int unsigned MaxOutstanding = 4,
   parameter type         way_inp_t      = logic,
   parameter type         way_oup_t      = logic,
   localparam int unsigned IdxW          = $clog2(NumReq),
   localparam int unsigned CntW          = $clog2(MaxOutstanding + 1)
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  way_inp_t            req_i [NumReq],
   input  logic [NumReq-1:0]   req_valid_i,
   output logic [NumReq-1:0]   req_ready_o,
   output way_inp_t            way_inp_o,
   output logic                way_inp_valid_o,
   input  logic                way_inp_ready_i,
   input  way_oup_t            way_out_i,
   input  logic                way_out_valid_i,
   output logic                way_out_ready_o,
   output way_oup_t            rsp_o [NumReq],
   output logic [NumReq-1:0]   rsp_valid_o,
   input  logic [NumReq-1:0]   rsp_ready_i,
   output logic [CntW-1:0]     outstanding_o,
   output logic                busy_o
);

   localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

   typedef logic [IdxW-1:0] idx_t;

   logic            r_active;
   idx_t            r_ptr;
   logic            r_lock;
   idx_t            r_lock_idx;
   idx_t            r_fifo [MaxOutstanding];
   logic [PtrW-1:0] r_wr;
   logic [PtrW-1:0] r_rd;
   logic [CntW-1:0] r_cnt;

   idx_t w_win;
   idx_t w_cand;
   idx_t w_sel;
   idx_t w_head;
   logic w_any;
   logic w_sel_valid;
   logic w_full;
   logic w_empty;
   logic w_push;
   logic w_pop;

   always_comb begin
      w_win  = '0;
      w_any  = 1'b0;
      w_cand = '0;
      for (int unsigned i = 0; i < NumReq; i++) begin
         w_cand = idx_t'((32'(r_ptr) + i) % NumReq);
         if (!w_any && req_valid_i[w_cand]) begin
            w_any = 1'b1;
            w_win = w_cand;
         end
      end
   end

   // Full is taken from the registered count, so a same-cycle pop cannot re-open issue.
   assign w_full      = (r_cnt == CntW'(MaxOutstanding));
   assign w_empty     = (r_cnt == '0);
   assign w_sel       = r_lock ? r_lock_idx : w_win;
   assign w_sel_valid = r_lock ? req_valid_i[r_lock_idx] : w_any;

   assign way_inp_valid_o = r_active && !w_full && w_sel_valid;
   assign way_inp_o       = req_i[w_sel];
   assign w_push          = way_inp_valid_o && way_inp_ready_i;

   always_comb begin
      req_ready_o        = '0;
      req_ready_o[w_sel] = w_push;
   end

   assign w_head = r_fifo[r_rd];

   always_comb begin
      rsp_valid_o     = '0;
      way_out_ready_o = 1'b0;
      if (!w_empty) begin
         rsp_valid_o[w_head] = way_out_valid_i;
         way_out_ready_o     = rsp_ready_i[w_head];
      end
      for (int unsigned i = 0; i < NumReq; i++) begin
         rsp_o[i] = way_out_i;
      end
   end

   assign w_pop         = way_out_valid_i && way_out_ready_o;
   assign outstanding_o = r_cnt;
   assign busy_o        = r_lock || !w_empty;

   // r_active keeps every output quiet while reset is held and for the first edge after it.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_active   <= 1'b0;
         r_ptr      <= '0;
         r_lock     <= 1'b0;
         r_lock_idx <= '0;
         r_wr       <= '0;
         r_rd       <= '0;
         r_cnt      <= '0;
      end else begin
         r_active <= 1'b1;
         if (w_push) begin
            r_ptr  <= (w_sel == idx_t'(NumReq - 1)) ? '0 : w_sel + 1'b1;
            r_lock <= 1'b0;
         end else if (way_inp_valid_o) begin
            r_lock     <= 1'b1;
            r_lock_idx <= w_sel;
         end
         if (w_push) begin
            r_wr <= (r_wr == PtrW'(MaxOutstanding - 1)) ? '0 : r_wr + 1'b1;
         end
         if (w_pop) begin
            r_rd <= (r_rd == PtrW'(MaxOutstanding - 1)) ? '0 : r_rd + 1'b1;
         end
         if (w_push && !w_pop) begin
            r_cnt <= r_cnt + 1'b1;
         end else if (!w_push && w_pop) begin
            r_cnt <= r_cnt - 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_fifo[r_wr] <= w_sel;
      end
   end

   a_hold_valid : assert property (@(posedge clk_i) disable iff (!rst_ni)
      r_lock |-> req_valid_i[r_lock_idx]);

   a_rsp_not_empty : assert property (@(posedge clk_i) disable iff (!rst_ni)
      way_out_valid_i |-> !w_empty);

endmodule

// File: tb/tb_axi_llc_way_port_arbiter.sv
// Randomized bench for axi_llc_way_port_arbiter against a queue-based reference model.
module tb_axi_llc_way_port_arbiter;

   localparam int unsigned NumReq = 2;
   localparam int unsigned MaxOut = 4;
   localparam int unsigned CntW   = $clog2(MaxOut + 1);

   typedef logic [7:0] data_t;
   typedef struct packed {
      int    owner;
      data_t data;
   } ent_t;

   logic              clk;
   logic              rst_n;
   data_t             req_data [NumReq];
   logic [NumReq-1:0] req_valid;
   logic [NumReq-1:0] req_ready;
   data_t             way_inp;
   logic              way_inp_valid;
   logic              way_inp_ready;
   data_t             way_out;
   logic              way_out_valid;
   logic              way_out_ready;
   data_t             rsp [NumReq];
   logic [NumReq-1:0] rsp_valid;
   logic [NumReq-1:0] rsp_ready;
   logic [CntW-1:0]   outstanding;
   logic              busy;

   axi_llc_way_port_arbiter #(
      .NumReq         (NumReq),
      .MaxOutstanding (MaxOut),
      .way_inp_t      (data_t),
      .way_oup_t      (data_t)
   ) u_dut (
      .clk_i           (clk),
      .rst_ni          (rst_n),
      .req_i           (req_data),
      .req_valid_i     (req_valid),
      .req_ready_o     (req_ready),
      .way_inp_o       (way_inp),
      .way_inp_valid_o (way_inp_valid),
      .way_inp_ready_i (way_inp_ready),
      .way_out_i       (way_out),
      .way_out_valid_i (way_out_valid),
      .way_out_ready_o (way_out_ready),
      .rsp_o           (rsp),
      .rsp_valid_o     (rsp_valid),
      .rsp_ready_i     (rsp_ready),
      .outstanding_o   (outstanding),
      .busy_o          (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference state: next-priority requester, locked requester (-1 = none), issue-order queue.
   int   m_ptr;
   int   m_lock;
   ent_t m_q [$];

   int p_req [NumReq];
   int p_rdy;
   int p_resp;
   int p_rr;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic chance(input int pct);
      return $urandom_range(99) < pct;
   endfunction

   // Called at posedge+1: compare on the falling edge, advance the model on the rising edge.
   task automatic step();
      int                sel;
      int                h;
      logic              selv;
      logic              e_vld;
      logic              e_wor;
      logic              push;
      logic              pop;
      logic [NumReq-1:0] e_rdy;
      logic [NumReq-1:0] e_rspv;
      data_t             e_data;
      ent_t              e;
      sel  = 0;
      h    = 0;
      selv = 1'b0;
      @(negedge clk);
      if (m_lock >= 0) begin
         sel  = m_lock;
         selv = req_valid[m_lock];
      end else begin
         for (int i = 0; i < NumReq; i++) begin
            int j;
            j = (m_ptr + i) % NumReq;
            if (!selv && req_valid[j]) begin
               selv = 1'b1;
               sel  = j;
            end
         end
      end
      e_vld = selv && (m_q.size() < MaxOut);
      e_rdy = '0;
      if (e_vld && way_inp_ready) e_rdy[sel] = 1'b1;
      e_rspv = '0;
      e_wor  = 1'b0;
      if (m_q.size() > 0) begin
         h         = m_q[0].owner;
         e_rspv[h] = way_out_valid;
         e_wor     = rsp_ready[h];
      end
      check_eq("way_inp_valid", 32'(way_inp_valid), 32'(e_vld));
      if (e_vld) check_eq("way_inp_data", 32'(way_inp), 32'(req_data[sel]));
      check_eq("req_ready", 32'(req_ready), 32'(e_rdy));
      check_eq("rsp_valid", 32'(rsp_valid), 32'(e_rspv));
      check_eq("way_out_ready", 32'(way_out_ready), 32'(e_wor));
      check_eq("outstanding", 32'(outstanding), m_q.size());
      check_eq("busy", 32'(busy), 32'((m_lock >= 0) || (m_q.size() != 0)));
      if (e_rspv != '0) begin
         e_data = ~m_q[0].data;
         check_eq("rsp_data", 32'(rsp[h]), 32'(e_data));
      end
      push = e_vld && way_inp_ready;
      pop  = (m_q.size() > 0) && way_out_valid && e_wor;
      @(posedge clk);
      if (pop) void'(m_q.pop_front());
      if (push) begin
         e.owner = sel;
         e.data  = req_data[sel];
         m_q.push_back(e);
         m_ptr  = (sel + 1) % NumReq;
         m_lock = -1;
      end else if (e_vld) begin
         m_lock = sel;
      end
      #1;
      if (pop) way_out_valid = 1'b0;
      if (push) req_valid[sel] = 1'b0;
      for (int k = 0; k < NumReq; k++) begin
         if (!req_valid[k] && chance(p_req[k])) begin
            req_valid[k] = 1'b1;
            req_data[k]  = data_t'($urandom);
         end
         rsp_ready[k] = chance(p_rr);
      end
      way_inp_ready = chance(p_rdy);
      if (!way_out_valid && (m_q.size() > 0) && chance(p_resp)) begin
         way_out_valid = 1'b1;
         way_out       = ~m_q[0].data;
      end
   endtask

   task automatic run(input int n, input int p0, input int p1, input int prdy, input int presp,
                      input int prr);
      p_req[0] = p0;
      p_req[1] = p1;
      p_rdy    = prdy;
      p_resp   = presp;
      p_rr     = prr;
      repeat (n) step();
   endtask

   task automatic reset_check(input string tag);
      check_eq({tag, "_way_inp_valid"}, 32'(way_inp_valid), 32'd0);
      check_eq({tag, "_req_ready"}, 32'(req_ready), 32'd0);
      check_eq({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
      check_eq({tag, "_way_out_ready"}, 32'(way_out_ready), 32'd0);
      check_eq({tag, "_outstanding"}, 32'(outstanding), 32'd0);
      check_eq({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   task automatic clear_inputs();
      req_valid     = '0;
      way_inp_ready = 1'b0;
      way_out_valid = 1'b0;
      way_out       = '0;
      rsp_ready     = '0;
      for (int k = 0; k < NumReq; k++) req_data[k] = '0;
      m_q.delete();
      m_ptr  = 0;
      m_lock = -1;
   endtask

   task automatic release_reset();
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      clear_inputs();
      req_valid     = '1;
      way_inp_ready = 1'b1;
      #2;
      reset_check("por");
      clear_inputs();
      release_reset();

      run(6, 100, 0, 100, 100, 100);
      run(20, 100, 100, 100, 60, 100);
      run(40, 100, 100, 20, 60, 100);
      run(30, 100, 100, 100, 0, 100);
      run(30, 100, 100, 100, 30, 100);
      run(60, 80, 80, 70, 80, 20);
      for (int p = 0; p < 15; p++) begin
         run(100, $urandom_range(100), $urandom_range(100), $urandom_range(100, 20),
             $urandom_range(100), $urandom_range(100, 10));
      end

      // Drain, build two outstanding requests from req 0, then stall so req 0 holds the lock.
      run(40, 0, 0, 100, 100, 100);
      run(2, 100, 0, 100, 0, 100);
      run(2, 100, 0, 0, 0, 100);
      rst_n = 1'b0;
      #1;
      reset_check("mid");
      clear_inputs();
      release_reset();
      run(3, 100, 100, 100, 50, 100);
      for (int p = 0; p < 3; p++) begin
         run(100, $urandom_range(100), $urandom_range(100), $urandom_range(100, 20),
             $urandom_range(100), $urandom_range(100, 10));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
